// File: rtl/bridge_pkg.sv
// rtl/bridge_pkg.sv - shared encodings and constants for the device bridge
package bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [31:0] DEV_REGION_LO = 32'h0000_7F00;
   localparam logic [31:0] DEV_REGION_HI = 32'h0000_7FFF;

   localparam int NUM_DEV    = 3;
   localparam int DEV_TIMER0 = 0;
   localparam int DEV_TIMER1 = 1;
   localparam int DEV_UART   = 2;

endpackage

// File: rtl/dev_bridge_if.sv
// rtl/dev_bridge_if.sv - CPU-side and device-side signals of the bridge
interface dev_bridge_if;
   import bridge_pkg::*;

   logic [31:0]        cpu_addr;
   logic [31:0]        cpu_wd;
   logic               cpu_we;
   logic               cpu_re;
   logic [31:0]        cpu_rd;
   logic               cpu_stall;
   logic               cpu_buserr;
   logic [NUM_DEV-1:0] dev_req;
   logic               dev_we;
   logic [1:0]         dev_addr;
   logic [31:0]        dev_wd;
   logic [NUM_DEV-1:0] dev_ack;
   logic [31:0]        dev_rd0;
   logic [31:0]        dev_rd1;
   logic [31:0]        dev_rd2;
   logic [NUM_DEV-1:0] dev_irq;
   logic [5:0]         hwint;

   modport master (
      input  cpu_addr, cpu_wd, cpu_we, cpu_re,
      input  dev_ack, dev_rd0, dev_rd1, dev_rd2, dev_irq,
      output cpu_rd, cpu_stall, cpu_buserr,
      output dev_req, dev_we, dev_addr, dev_wd, hwint
   );

   modport slave (
      output cpu_addr, cpu_wd, cpu_we, cpu_re,
      output dev_ack, dev_rd0, dev_rd1, dev_rd2, dev_irq,
      input  cpu_rd, cpu_stall, cpu_buserr,
      input  dev_req, dev_we, dev_addr, dev_wd, hwint
   );

endinterface

// File: rtl/dev_addr_decode.sv
// rtl/dev_addr_decode.sv - maps a data address to a one-hot device hit and a region flag
module dev_addr_decode
   import bridge_pkg::*;
#(
   parameter logic [31:0] BASE0 = 32'h0000_7F00,
   parameter logic [31:0] BASE1 = 32'h0000_7F10,
   parameter logic [31:0] BASE2 = 32'h0000_7F20
) (
   input  logic [31:0]        cpu_addr,
   output logic [NUM_DEV-1:0] hit,
   output logic               in_region
);

   assign hit[DEV_TIMER0] = (cpu_addr[31:4] == BASE0[31:4]);
   assign hit[DEV_TIMER1] = (cpu_addr[31:4] == BASE1[31:4]);
   assign hit[DEV_UART]   = (cpu_addr[31:4] == BASE2[31:4]);

   assign in_region = (cpu_addr >= DEV_REGION_LO) && (cpu_addr <= DEV_REGION_HI);

endmodule

// File: rtl/dev_bridge.sv
// rtl/dev_bridge.sv - MEM-stage to peripheral req/ack bridge with stall, timeout and irq sync
module dev_bridge
   import bridge_pkg::*;
#(
   parameter logic [31:0] BASE0   = 32'h0000_7F00,
   parameter logic [31:0] BASE1   = 32'h0000_7F10,
   parameter logic [31:0] BASE2   = 32'h0000_7F20,
   parameter int          TIMEOUT = 15
) (
   input logic          clk,
   input logic          reset,
   dev_bridge_if.master bus
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_e             state_q, state_d;
   logic [1:0]         sel_q, sel_d;
   logic [NUM_DEV-1:0] req_q, req_d;
   logic               we_q, we_d;
   logic [1:0]         addr_q, addr_d;
   logic [31:0]        wd_q, wd_d;
   logic [31:0]        rd_q, rd_d;
   logic [7:0]         cnt_q, cnt_d;
   logic               to_q, to_d;
   logic [NUM_DEV-1:0] irq_q, irq_d;

   logic [NUM_DEV-1:0] hit;
   logic               in_region;
   logic               access;
   logic [1:0]         hit_idx;
   logic [31:0]        rd_sel;

   dev_addr_decode #(.BASE0(BASE0), .BASE1(BASE1), .BASE2(BASE2)) u_decode (
      .cpu_addr  (bus.cpu_addr),
      .hit       (hit),
      .in_region (in_region)
   );

   // Gating with reset keeps the combinational stall/buserr low while held in reset.
   assign access = (bus.cpu_we | bus.cpu_re) & reset;

   always_comb begin
      hit_idx = 2'd2;
      if (hit[DEV_TIMER0])      hit_idx = 2'd0;
      else if (hit[DEV_TIMER1]) hit_idx = 2'd1;
   end

   always_comb begin
      rd_sel = 32'h0;
      case (sel_q)
         2'd0:    rd_sel = bus.dev_rd0;
         2'd1:    rd_sel = bus.dev_rd1;
         2'd2:    rd_sel = bus.dev_rd2;
         default: rd_sel = 32'h0;
      endcase
   end

   always_comb begin
      state_d        = state_q;
      sel_d          = sel_q;
      req_d          = req_q;
      we_d           = we_q;
      addr_d         = addr_q;
      wd_d           = wd_q;
      rd_d           = rd_q;
      cnt_d          = cnt_q;
      to_d           = to_q;
      irq_d          = bus.dev_irq;
      bus.cpu_stall  = 1'b0;
      bus.cpu_buserr = 1'b0;
      bus.cpu_rd     = 32'h0;
      case (state_q)
         ST_IDLE: begin
            if (access && (|hit)) begin
               sel_d         = hit_idx;
               we_d          = bus.cpu_we;
               addr_d        = bus.cpu_addr[3:2];
               wd_d          = bus.cpu_wd;
               req_d         = 3'b001 << hit_idx;
               cnt_d         = 8'd0;
               to_d          = 1'b0;
               state_d       = ST_BUSY;
               bus.cpu_stall = 1'b1;
            end else if (access && in_region) begin
               bus.cpu_buserr = 1'b1;
            end
         end
         ST_BUSY: begin
            bus.cpu_stall = 1'b1;
            if (bus.dev_ack[sel_q]) begin
               rd_d    = we_q ? 32'h0 : rd_sel;
               req_d   = '0;
               state_d = ST_DONE;
            end else if (cnt_q == TO_LAST) begin
               rd_d    = 32'h0;
               to_d    = 1'b1;
               req_d   = '0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_DONE: begin
            bus.cpu_rd     = rd_q;
            bus.cpu_buserr = to_q;
            to_d           = 1'b0;
            state_d        = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         sel_q   <= 2'd0;
         req_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= 2'd0;
         wd_q    <= 32'h0;
         rd_q    <= 32'h0;
         cnt_q   <= 8'd0;
         to_q    <= 1'b0;
         irq_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wd_q    <= wd_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         to_q    <= to_d;
         irq_q   <= irq_d;
      end
   end

   assign bus.dev_req  = req_q;
   assign bus.dev_we   = we_q;
   assign bus.dev_addr = addr_q;
   assign bus.dev_wd   = wd_q;
   assign bus.hwint    = {3'b000, irq_q};

endmodule

// File: tb/tb_dev_bridge.sv
// tb/tb_dev_bridge.sv - directed self-checking bench for dev_bridge
module tb_dev_bridge;

   logic clk;
   logic reset;
   int   tests;
   int   fails;
   int   n;

   dev_bridge_if bus ();

   dev_bridge dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b0;
      bus.cpu_addr = 32'h0;
      bus.cpu_wd   = 32'h0;
      bus.cpu_we   = 1'b0;
      bus.cpu_re   = 1'b0;
      bus.dev_ack  = 3'b000;
      bus.dev_rd0  = 32'h0;
      bus.dev_rd1  = 32'h0;
      bus.dev_rd2  = 32'h0;
      bus.dev_irq  = 3'b000;
      settle();
      chk("rst_rd",     bus.cpu_rd,     32'h0);
      chk("rst_stall",  bus.cpu_stall,  32'h0);
      chk("rst_buserr", bus.cpu_buserr, 32'h0);
      chk("rst_req",    bus.dev_req,    32'h0);
      chk("rst_we",     bus.dev_we,     32'h0);
      chk("rst_addr",   bus.dev_addr,   32'h0);
      chk("rst_wd",     bus.dev_wd,     32'h0);
      chk("rst_hwint",  bus.hwint,      32'h0);
      cyc();
      reset = 1'b1;
      cyc();

      // load 0x7F14, device 1 acks on the third cycle after dev_req rises
      bus.cpu_addr = 32'h0000_7F14;
      bus.cpu_re   = 1'b1;
      settle();
      chk("ld1_c0_stall", bus.cpu_stall, 32'h1);
      chk("ld1_c0_req",   bus.dev_req,   32'h0);
      cyc();
      chk("ld1_c1_req",   bus.dev_req,   32'h2);
      chk("ld1_c1_addr",  bus.dev_addr,  32'h1);
      chk("ld1_c1_stall", bus.cpu_stall, 32'h1);
      cyc();
      chk("ld1_c2_stall", bus.cpu_stall, 32'h1);
      cyc();
      chk("ld1_c3_req",   bus.dev_req,   32'h2);
      cyc();
      bus.dev_ack = 3'b010;
      bus.dev_rd1 = 32'hCAFE_0001;
      settle();
      chk("ld1_c4_stall", bus.cpu_stall, 32'h1);
      cyc();
      bus.dev_ack = 3'b000;
      bus.cpu_re  = 1'b0;
      settle();
      chk("ld1_done_stall",  bus.cpu_stall,  32'h0);
      chk("ld1_done_rd",     bus.cpu_rd,     32'hCAFE_0001);
      chk("ld1_done_req",    bus.dev_req,    32'h0);
      chk("ld1_done_buserr", bus.cpu_buserr, 32'h0);
      cyc();
      chk("ld1_after_rd",    bus.cpu_rd,     32'h0);
      chk("ld1_after_stall", bus.cpu_stall,  32'h0);

      // store 0x1234 to UART, ack in first BUSY cycle
      bus.cpu_addr = 32'h0000_7F20;
      bus.cpu_wd   = 32'h0000_1234;
      bus.cpu_we   = 1'b1;
      settle();
      chk("st_c0_stall", bus.cpu_stall, 32'h1);
      cyc();
      bus.dev_ack = 3'b100;
      settle();
      chk("st_c1_we",    bus.dev_we,    32'h1);
      chk("st_c1_wd",    bus.dev_wd,    32'h0000_1234);
      chk("st_c1_req",   bus.dev_req,   32'h4);
      chk("st_c1_stall", bus.cpu_stall, 32'h1);
      cyc();
      bus.dev_ack = 3'b000;
      bus.cpu_we  = 1'b0;
      settle();
      chk("st_done_stall",  bus.cpu_stall,  32'h0);
      chk("st_done_buserr", bus.cpu_buserr, 32'h0);
      chk("st_done_rd",     bus.cpu_rd,     32'h0);
      cyc();

      // unmapped inside region, then outside region
      bus.cpu_addr = 32'h0000_7F40;
      bus.cpu_re   = 1'b1;
      settle();
      chk("unm_buserr", bus.cpu_buserr, 32'h1);
      chk("unm_stall",  bus.cpu_stall,  32'h0);
      chk("unm_req",    bus.dev_req,    32'h0);
      cyc();
      bus.cpu_addr = 32'h0000_1000;
      settle();
      chk("out_buserr", bus.cpu_buserr, 32'h0);
      chk("out_stall",  bus.cpu_stall,  32'h0);
      chk("out_req",    bus.dev_req,    32'h0);
      chk("out_rd",     bus.cpu_rd,     32'h0);
      cyc();

      // timeout on device 0 with a spurious ack from device 1
      bus.cpu_addr = 32'h0000_7F00;
      bus.dev_rd1  = 32'h1111_2222;
      settle();
      n = 0;
      while (bus.cpu_stall === 1'b1 && n < 40) begin
         n++;
         bus.dev_ack = (n == 3) ? 3'b010 : 3'b000;
         cyc();
      end
      bus.dev_ack = 3'b000;
      bus.cpu_re  = 1'b0;
      settle();
      chk("to_stall_cycles", n,              32'd16);
      chk("to_done_rd",      bus.cpu_rd,     32'h0);
      chk("to_done_buserr",  bus.cpu_buserr, 32'h1);
      chk("to_done_stall",   bus.cpu_stall,  32'h0);
      cyc();
      chk("to_after_buserr", bus.cpu_buserr, 32'h0);

      // reset in the second BUSY cycle, then repeat the access
      bus.cpu_addr = 32'h0000_7F14;
      bus.cpu_re   = 1'b1;
      bus.dev_rd1  = 32'h5555_AAAA;
      cyc();
      cyc();
      chk("rmid_req_before", bus.dev_req, 32'h2);
      reset = 1'b0;
      settle();
      chk("rmid_req",    bus.dev_req,    32'h0);
      chk("rmid_stall",  bus.cpu_stall,  32'h0);
      chk("rmid_buserr", bus.cpu_buserr, 32'h0);
      chk("rmid_rd",     bus.cpu_rd,     32'h0);
      chk("rmid_addr",   bus.dev_addr,   32'h0);
      chk("rmid_wd",     bus.dev_wd,     32'h0);
      cyc();
      reset = 1'b1;
      settle();
      chk("rrel_c0_stall", bus.cpu_stall, 32'h1);
      cyc();
      bus.dev_ack = 3'b010;
      settle();
      chk("rrel_c1_req", bus.dev_req, 32'h2);
      cyc();
      bus.dev_ack = 3'b000;
      bus.cpu_re  = 1'b0;
      settle();
      chk("rrel_done_rd",    bus.cpu_rd,    32'h5555_AAAA);
      chk("rrel_done_stall", bus.cpu_stall, 32'h0);
      cyc();

      // irq lag and write priority when both we and re are high
      bus.dev_irq = 3'b101;
      settle();
      chk("irq_n",  bus.hwint, 32'h0);
      cyc();
      chk("irq_n1", bus.hwint, 32'h05);
      bus.cpu_addr = 32'h0000_7F10;
      bus.cpu_wd   = 32'hDEAD_BEEF;
      bus.cpu_we   = 1'b1;
      bus.cpu_re   = 1'b1;
      bus.dev_rd1  = 32'h7777_7777;
      cyc();
      bus.dev_ack = 3'b010;
      settle();
      chk("both_we",  bus.dev_we,  32'h1);
      chk("both_req", bus.dev_req, 32'h2);
      chk("both_wd",  bus.dev_wd,  32'hDEAD_BEEF);
      cyc();
      bus.dev_ack = 3'b000;
      bus.cpu_we  = 1'b0;
      bus.cpu_re  = 1'b0;
      bus.dev_irq = 3'b000;
      settle();
      chk("both_done_rd", bus.cpu_rd, 32'h0);
      chk("irq_hold",     bus.hwint,  32'h05);
      cyc();
      chk("irq_clear",    bus.hwint,  32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
